clk_rst_interface: RTL and testbench
====================================

CLK_RST_INTERFACE -- requirements
Module: clk_rst_interface

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: port clk (clock) and port rst_n (reset).
REQ-002 Parameter MODE, default 0, selects the mode: 0 = dump (count only), 1 = read (compare against a reference count).
REQ-003 Parameter ACTIVE, default 1'b1: 1 = block enabled; 0 = all counters held at 0 and all outputs held at reset values.
REQ-004 Parameter CW, default 32, sets the counter width.
REQ-005 Ports, one per line (name  direction  width  meaning):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  block start handshake, sampled at posedge clk
- ap_ready  in  1  block ready handshake, sampled at posedge clk
- ref_trans_cnt  in  CW  expected transaction count (read mode)
- chk  in  1  single-cycle end-of-run check strobe
- rst_sync_n  out  1  reset, asserted asynchronously, deasserted synchronously
- cycle_cnt  out  CW  clock cycles since reset release
- trans_cnt  out  CW  counted transactions
- wait_next  out  1  high while waiting for the next start
- cnt_mismatch  out  1  sticky count-mismatch flag (present only with the macro)

Function
REQ-006 rst_sync_n SHALL be a 2-flop synchronizer: asserts (0) immediately on rst_n=0 and deasserts on the 2nd posedge clk after rst_n rises.
REQ-007 All other logic SHALL be reset by rst_sync_n.
REQ-008 cycle_cnt SHALL increment by 1 on every posedge while rst_sync_n=1 and saturate at all-ones.
REQ-009 Transaction FSM states: IDLE, RUN, WAIT.
REQ-010 IDLE: register ap_start as start_q; when ap_start=1 && start_q=0 (rising edge), trans_cnt<=1 and go to RUN. If ap_start is already 1 out of reset, this is not a rising edge.
REQ-011 RUN: when ap_start=1 && ap_ready=1 at a posedge, go to WAIT; trans_cnt is unchanged.
REQ-012 WAIT: at each later posedge where ap_start=1, trans_cnt increments by 1 and the FSM returns to RUN. ap_ready is ignored at that same edge.
REQ-013 Back-to-back behaviour: with ap_start held high and ap_ready high every cycle, trans_cnt increments every 2nd cycle.
REQ-014 wait_next SHALL equal 1 exactly in state WAIT.
REQ-015 trans_cnt SHALL saturate at all-ones; on saturation the FSM continues and the counter holds.
REQ-016 Unknown (X/Z) ap_start or ap_ready SHALL be treated as 0 (===1 semantics in simulation).

Reset
REQ-017 Reset values: rst_sync_n=0, cycle_cnt=0, trans_cnt=0, wait_next=0, cnt_mismatch=0, FSM=IDLE, start_q=0.
REQ-018 Reset asserted mid-operation SHALL immediately return all of the above to their reset values.
REQ-019 After reset, a new rising edge of ap_start is required before counting resumes.

Configuration
REQ-020 Macro CLK_RST_REF_CHECK_EN defined: cnt_mismatch exists. In MODE=1, a chk pulse with trans_cnt != ref_trans_cnt sets cnt_mismatch, which stays set until reset. In MODE=0, cnt_mismatch stays 0.
REQ-021 Macro CLK_RST_REF_CHECK_EN undefined: the cnt_mismatch port and the compare logic are absent; chk and ref_trans_cnt are unused.

Structure
REQ-022 Package clk_rst_pkg SHALL hold the FSM state enum, the MODE_DUMP=0 and MODE_READ=1 constants, and the default CW.
REQ-023 Sub-module rst_sync SHALL implement the 2-flop reset synchronizer; all other logic lives in the top module.

Verification
REQ-024 rst_n low for 3 cycles, then high -> rst_sync_n rises on the 2nd posedge; cycle_cnt=0 at that time, then increments by 1 per cycle.
REQ-025 ap_start 0->1 with ap_ready=0 for 5 cycles -> trans_cnt=1, wait_next=0.
REQ-026 Three start/ready handshakes, each followed by 2 idle cycles and then a new ap_start=1 -> trans_cnt=3 and wait_next=1 after the last ready.
REQ-027 ap_start and ap_ready held at 1 for 10 cycles after the first rising edge -> trans_cnt increments every 2nd cycle, giving 5 or 6.
REQ-028 MODE=1 with the macro defined, ref_trans_cnt=4, trans_cnt=3, chk pulse -> cnt_mismatch=1 and stays set; with ref_trans_cnt=3 -> cnt_mismatch stays 0.
REQ-029 rst_n pulsed low while in WAIT -> all outputs return to 0 asynchronously; a subsequent ap_start held at 1 is not counted until it falls and rises again.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock/reset interface block.
package clk_rst_pkg;

  localparam int MODE_DUMP  = 0;
  localparam int MODE_READ  = 1;
  localparam int CW_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Transaction FSM state bundled for observation by bound checkers.
  typedef struct packed {
    state_t state;
    logic   start_q;
    logic   seen_low;
  } fsm_dbg_t;

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the 2nd clock edge.
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      meta       <= 1'b1;
      rst_sync_n <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_interface.sv
// Reset synchronizer, free-running cycle counter and start/ready transaction counter.
// Optional reference-count check is built when CLK_RST_REF_CHECK_EN is defined.
module clk_rst_interface
  import clk_rst_pkg::*;
#(
  parameter int MODE   = MODE_DUMP,
  parameter bit ACTIVE = 1'b1,
  parameter int CW     = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ap_start,
  input  logic          ap_ready,
  input  logic [CW-1:0] ref_trans_cnt,
  input  logic          chk,
  output logic          rst_sync_n,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] trans_cnt,
  output logic          wait_next
`ifdef CLK_RST_REF_CHECK_EN
  ,
  output logic          cnt_mismatch
`endif
);

  logic     sync_n;
  logic     rst_int_n;
  logic     start_v;
  logic     ready_v;
  fsm_dbg_t fsm;

  rst_sync u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (sync_n)
  );

  // An inactive block is held in reset permanently.
  assign rst_int_n  = sync_n & ACTIVE;
  assign rst_sync_n = rst_int_n;

  assign start_v = (ap_start === 1'b1);
  assign ready_v = (ap_ready === 1'b1);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cycle_cnt <= '0;
    end else if (cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + CW'(1);
    end
  end

  // Handshake: a transaction opens on a rising ap_start, closes when ap_start and
  // ap_ready are both high at an edge, and the next one opens on any later edge
  // with ap_start high (ap_ready ignored at that edge). seen_low keeps a start
  // that is already high out of reset from counting as a rising edge.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      fsm.state    <= ST_IDLE;
      fsm.start_q  <= 1'b0;
      fsm.seen_low <= 1'b0;
      trans_cnt    <= '0;
      wait_next    <= 1'b0;
    end else begin
      case (fsm.state)
        ST_IDLE: begin
          fsm.start_q <= start_v;
          if (!start_v) fsm.seen_low <= 1'b1;
          if (start_v && !fsm.start_q && fsm.seen_low) begin
            trans_cnt <= CW'(1);
            fsm.state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (start_v && ready_v) begin
            fsm.state <= ST_WAIT;
            wait_next <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (start_v) begin
            fsm.state <= ST_RUN;
            wait_next <= 1'b0;
            if (trans_cnt != '1) trans_cnt <= trans_cnt + CW'(1);
          end
        end
        default: begin
          fsm.state <= ST_IDLE;
          wait_next <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_RST_REF_CHECK_EN
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_mismatch <= 1'b0;
    end else if ((MODE == MODE_READ) && chk && (trans_cnt != ref_trans_cnt)) begin
      cnt_mismatch <= 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{chk, ref_trans_cnt, (MODE == MODE_READ)};
`endif

endmodule

// File: tb/tb_clk_rst_interface.sv
// Directed self-checking bench for clk_rst_interface (full-width, narrow and inactive builds).
module tb_clk_rst_interface;
  import clk_rst_pkg::*;

  localparam int CW  = 32;
  localparam int CWS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ap_start;
  logic          ap_ready;
  logic          chk;
  logic [CW-1:0] ref_trans_cnt;

  logic           rst_sync_n,   rst_sync_n_s,   rst_sync_n_i;
  logic [CW-1:0]  cycle_cnt,    cycle_cnt_i;
  logic [CW-1:0]  trans_cnt,    trans_cnt_i;
  logic [CWS-1:0] cycle_cnt_s,  trans_cnt_s;
  logic           wait_next,    wait_next_s,    wait_next_i;
`ifdef CLK_RST_REF_CHECK_EN
  logic           cnt_mismatch, cnt_mismatch_s, cnt_mismatch_i;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_q[$];

  always #5 clk = ~clk;

  clk_rst_interface #(.MODE(MODE_READ), .ACTIVE(1'b1), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ref_trans_cnt(ref_trans_cnt), .chk(chk), .rst_sync_n(rst_sync_n),
    .cycle_cnt(cycle_cnt), .trans_cnt(trans_cnt), .wait_next(wait_next)
`ifdef CLK_RST_REF_CHECK_EN
    , .cnt_mismatch(cnt_mismatch)
`endif
  );

  clk_rst_interface #(.MODE(MODE_DUMP), .ACTIVE(1'b1), .CW(CWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ref_trans_cnt(ref_trans_cnt[CWS-1:0]), .chk(chk), .rst_sync_n(rst_sync_n_s),
    .cycle_cnt(cycle_cnt_s), .trans_cnt(trans_cnt_s), .wait_next(wait_next_s)
`ifdef CLK_RST_REF_CHECK_EN
    , .cnt_mismatch(cnt_mismatch_s)
`endif
  );

  clk_rst_interface #(.MODE(MODE_READ), .ACTIVE(1'b0), .CW(CW)) dut_i (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ref_trans_cnt(ref_trans_cnt), .chk(chk), .rst_sync_n(rst_sync_n_i),
    .cycle_cnt(cycle_cnt_i), .trans_cnt(trans_cnt_i), .wait_next(wait_next_i)
`ifdef CLK_RST_REF_CHECK_EN
    , .cnt_mismatch(cnt_mismatch_i)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [CW-1:0] e;
    rst_n = 1'b0; ap_start = 1'b0; ap_ready = 1'b0; chk = 1'b0; ref_trans_cnt = '0;

    // reset held low for 3 cycles
    tick(3);
    check("rst_sync_n_reset", CW'(rst_sync_n), 0);
    check("cycle_reset", cycle_cnt, 0);
    check("trans_reset", trans_cnt, 0);
    check("wait_reset", CW'(wait_next), 0);
`ifdef CLK_RST_REF_CHECK_EN
    check("mismatch_reset", CW'(cnt_mismatch), 0);
`endif

    rst_n = 1'b1;
    tick(1);
    check("rst_sync_n_edge1", CW'(rst_sync_n), 0);
    tick(1);
    check("rst_sync_n_edge2", CW'(rst_sync_n), 1);
    check("cycle_at_release", cycle_cnt, 0);
    tick(1);
    check("cycle_plus1", cycle_cnt, 1);
    tick(1);
    check("cycle_plus2", cycle_cnt, 2);

    // single start, no ready
    ap_start = 1'b1;
    tick(5);
    check("start_only_trans", trans_cnt, 1);
    check("start_only_wait", CW'(wait_next), 0);

    // three handshakes separated by idle gaps
    for (int h = 0; h < 3; h++) begin
      if (h > 0) begin
        ap_start = 1'b0; ap_ready = 1'b0;
        tick(2);
        check("gap_wait", CW'(wait_next), 1);
        ap_start = 1'b1;
        tick(1);
        check("restart_trans", trans_cnt, CW'(h + 1));
        check("restart_wait", CW'(wait_next), 0);
      end
      ap_ready = 1'b1;
      tick(1);
      check("hs_wait", CW'(wait_next), 1);
      check("hs_trans", trans_cnt, CW'(h + 1));
    end
    ap_start = 1'b0; ap_ready = 1'b0;
    tick(1);
    check("after_hs_trans", trans_cnt, 3);
    check("after_hs_wait", CW'(wait_next), 1);

`ifdef CLK_RST_REF_CHECK_EN
    ref_trans_cnt = 4;
    tick(1);
    check("mm_no_chk", CW'(cnt_mismatch), 0);
    ref_trans_cnt = 3; chk = 1'b1;
    tick(1);
    chk = 1'b0;
    check("mm_equal", CW'(cnt_mismatch), 0);
    ref_trans_cnt = 4; chk = 1'b1;
    tick(1);
    chk = 1'b0;
    check("mm_set", CW'(cnt_mismatch), 1);
    check("mm_dump_mode", CW'(cnt_mismatch_s), 0);
    ref_trans_cnt = 3;
    tick(3);
    check("mm_sticky", CW'(cnt_mismatch), 1);
`endif

    // asynchronous reset while in WAIT
    rst_n = 1'b0;
    #1;
    check("async_rst_sync_n", CW'(rst_sync_n), 0);
    check("async_cycle", cycle_cnt, 0);
    check("async_trans", trans_cnt, 0);
    check("async_wait", CW'(wait_next), 0);
`ifdef CLK_RST_REF_CHECK_EN
    check("async_mm", CW'(cnt_mismatch), 0);
`endif
    ap_start = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check("held_start_trans", trans_cnt, 0);
    check("held_start_wait", CW'(wait_next), 0);
    check("cycle_after_rerst", cycle_cnt, 2);
    ap_start = 1'b0;
    tick(1);
    ap_start = 1'b1;
    tick(1);
    check("new_rise_trans", trans_cnt, 1);

    // back-to-back start/ready: count advances every 2nd edge
    ap_ready = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      exp_q.push_back(CW'(1 + i / 2));
      tick(1);
      e = exp_q.pop_front();
      check("b2b_trans", trans_cnt, e);
      check("b2b_wait", CW'(wait_next), CW'(i % 2));
      check("b2b_trans_sat", CW'(trans_cnt_s), (e > 7) ? 7 : e);
    end
    check("b2b_10_cycles", CW'(1 + 10 / 2), 6);
    ap_start = 1'b0; ap_ready = 1'b0;
    tick(1);
    check("cycle_sat_narrow", CW'(cycle_cnt_s), 7);
    check("inactive_rst_sync_n", CW'(rst_sync_n_i), 0);
    check("inactive_cycle", cycle_cnt_i, 0);
    check("inactive_trans", trans_cnt_i, 0);
    check("inactive_wait", CW'(wait_next_i), 0);
`ifdef CLK_RST_REF_CHECK_EN
    check("inactive_mm", CW'(cnt_mismatch_i), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
